// File: rtl/pdp8_trace_pkg.sv
// pdp8_trace_pkg: shared definitions for the PDP-8 instruction-trace recorder.
//   ENTRY_W / field offsets : layout of one trace entry {pc, ir, l, ac, ion}
//   trace_state_e           : capture FSM encoding
//   pack_entry()            : builds an entry from the snooped CPU fields
package pdp8_trace_pkg;

    localparam int ENTRY_W = 38;
    localparam int PC_LSB  = 26;
    localparam int IR_LSB  = 14;
    localparam int L_BIT   = 13;
    localparam int AC_LSB  = 1;
    localparam int ION_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [11:0] pc,
        input logic [11:0] ir,
        input logic        l,
        input logic [11:0] ac,
        input logic        ion
    );
        return {pc, ir, l, ac, ion};
    endfunction

endpackage

// File: rtl/pdp8_trace_if.sv
// pdp8_trace_if: bundle of CPU snoop, control, read-port and status signals
// for the trace recorder.
//   master : drives CPU snoop, arm/stop/config and read requests; sees status
//   slave  : the recorder itself
interface pdp8_trace_if #(
    parameter int DEPTH_LOG2 = 6,
    parameter int STATE_W    = 4,
    parameter int CYCLE_W    = 32
) ();
    // CPU snoop
    logic [STATE_W-1:0]    cpu_state;
    logic [11:0]           cpu_pc;
    logic [11:0]           cpu_mb;
    logic                  cpu_l;
    logic [11:0]           cpu_ac;
    logic                  cpu_ion;
    // control
    logic                  arm;
    logic                  stop;
    logic                  wrap_en;
    logic                  trig_pc_en;
    logic [11:0]           trig_pc;
    logic [DEPTH_LOG2:0]   post_count;
    // read port
    logic                  rd_en;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [37:0]           rd_data;
    logic                  rd_valid;
    logic                  rd_err;
    // status
    logic                  busy;
    logic                  done;
    logic                  triggered;
    logic [DEPTH_LOG2:0]   entries;
    logic [CYCLE_W-1:0]    cycle_count;

    modport master (
        output cpu_state, cpu_pc, cpu_mb, cpu_l, cpu_ac, cpu_ion,
               arm, stop, wrap_en, trig_pc_en, trig_pc, post_count,
               rd_en, rd_addr,
        input  rd_data, rd_valid, rd_err, busy, done, triggered, entries, cycle_count
    );

    modport slave (
        input  cpu_state, cpu_pc, cpu_mb, cpu_l, cpu_ac, cpu_ion,
               arm, stop, wrap_en, trig_pc_en, trig_pc, post_count,
               rd_en, rd_addr,
        output rd_data, rd_valid, rd_err, busy, done, triggered, entries, cycle_count
    );
endinterface

// File: rtl/pdp8_trace_ram.sv
// pdp8_trace_ram: simple dual-port trace buffer, one write port and one
// synchronous read port (latency 1, read-before-write on address collision).
//   clk           : clock
//   wr_en_i       : write strobe, wr_addr_i / wr_data_i
//   rd_en_i       : read strobe, rd_addr_i -> rd_data_o on the next cycle
module pdp8_trace_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 38
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto block RAM; stale contents
    // are never exposed because the top masks reads beyond the valid entries.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        // NOTE: non-blocking assignments make a same-address read see the old
        // word, which is the read-before-write behaviour block RAM provides.
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/pdp8_trace.sv
// pdp8_trace: instruction-trace recorder for the PDP-8 core. Logs one entry
// {pc, ir, l, ac, ion} per entry into the fetch state into a circular buffer,
// with halt / PC-match triggers, post-trigger count, one-shot or wrap mode and
// a saturating fetch counter.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : pdp8_trace_if slave (CPU snoop, control, read port, status)
module pdp8_trace
    import pdp8_trace_pkg::*;
#(
    parameter int                 DEPTH_LOG2  = 6,
    parameter int                 STATE_W     = 4,
    parameter logic [STATE_W-1:0] FETCH_STATE = 4'b0000,
    parameter logic [STATE_W-1:0] HALT_STATE  = 4'b1100,
    parameter int                 CYCLE_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    pdp8_trace_if.slave bus
);
    localparam int                  DEPTH     = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

    trace_state_e          state_q;
    logic [STATE_W-1:0]    prev_state_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2:0]   entries_q, entries_d;
    logic [DEPTH_LOG2:0]   remaining_q;
    logic [CYCLE_W-1:0]    cycle_q, cycle_d;
    logic                  triggered_q;
    logic                  wrap_q;
    logic                  rd_valid_q;
    logic                  rd_err_q, rd_err_d;

    logic                  fetch_evt, trigger, wr_en, fill_done;
    logic [DEPTH_LOG2-1:0] rd_phys;
    logic [ENTRY_W-1:0]    wr_data, ram_rdata;

    // Rising edge into fetch: a multi-cycle fetch produces a single entry.
    assign fetch_evt = (bus.cpu_state == FETCH_STATE) && (prev_state_q != FETCH_STATE);
    assign trigger   = (bus.cpu_state == HALT_STATE) ||
                       (bus.trig_pc_en && fetch_evt && (bus.cpu_pc == bus.trig_pc));

    // arm and stop both pre-empt capture in the cycle they are seen.
    assign wr_en = fetch_evt && !bus.arm && !bus.stop &&
                   ((state_q == ST_ARMED) || (state_q == ST_POST));

    assign entries_d = (entries_q == DEPTH_CNT) ? entries_q : entries_q + 1'b1;
    assign cycle_d   = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
    assign fill_done = wr_en && !wrap_q && (entries_d == DEPTH_CNT);

    assign wr_data = pack_entry(bus.cpu_pc, bus.cpu_mb, bus.cpu_l, bus.cpu_ac, bus.cpu_ion);

    // Once the buffer has filled, wr_ptr points at the oldest entry.
    assign rd_phys  = ((entries_q == DEPTH_CNT) ? wr_ptr_q : '0) + bus.rd_addr;
    assign rd_err_d = ({1'b0, bus.rd_addr} >= entries_q);

    pdp8_trace_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (ENTRY_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data),
        .rd_en_i   (bus.rd_en),
        .rd_addr_i (rd_phys),
        .rd_data_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            prev_state_q <= ~FETCH_STATE;
            wr_ptr_q     <= '0;
            entries_q    <= '0;
            remaining_q  <= '0;
            cycle_q      <= '0;
            triggered_q  <= 1'b0;
            wrap_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            prev_state_q <= bus.cpu_state;
            rd_valid_q   <= bus.rd_en;
            rd_err_q     <= bus.rd_en && rd_err_d;

            if (bus.arm) begin
                state_q     <= ST_ARMED;
                wr_ptr_q    <= '0;
                entries_q   <= '0;
                remaining_q <= '0;
                cycle_q     <= '0;
                triggered_q <= 1'b0;
                wrap_q      <= bus.wrap_en;
            end else if (bus.stop && (state_q != ST_IDLE)) begin
                state_q <= ST_DONE;
            end else begin
                if (wr_en) begin
                    wr_ptr_q  <= wr_ptr_q + 1'b1;
                    entries_q <= entries_d;
                    cycle_q   <= cycle_d;
                end
                case (state_q)
                    ST_ARMED: begin
                        // The trigger capture itself does not consume post_count.
                        if (trigger) begin
                            triggered_q <= 1'b1;
                            remaining_q <= bus.post_count;
                        end
                        if (fill_done || (trigger && (bus.post_count == '0))) begin
                            state_q <= ST_DONE;
                        end else if (trigger) begin
                            state_q <= ST_POST;
                        end
                    end
                    ST_POST: begin
                        if (wr_en) begin
                            remaining_q <= remaining_q - 1'b1;
                            if ((remaining_q == 1) || fill_done) begin
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy        = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.triggered   = triggered_q;
    assign bus.entries     = entries_q;
    assign bus.cycle_count = cycle_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_err      = rd_err_q;
    assign bus.rd_data     = (rd_valid_q && !rd_err_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_pdp8_trace.sv
// tb_pdp8_trace: directed bench for pdp8_trace (DEPTH_LOG2 = 3, 8 entries).
// Read requests push the expected {data, err} into a scoreboard queue; a
// monitor pops and compares whenever rd_valid is seen. Status outputs are
// compared directly against hand-computed constants.
module tb_pdp8_trace;
    localparam int DL2 = 3;

    typedef struct {
        logic [37:0] data;
        logic        err;
        string       name;
    } rd_exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    rd_exp_t sb[$];

    pdp8_trace_if #(.DEPTH_LOG2(DL2), .STATE_W(4), .CYCLE_W(32)) bus ();

    pdp8_trace #(.DEPTH_LOG2(DL2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Fields for the k-th fetch of a sequence are derived from k.
    function automatic logic [37:0] exp_entry(input logic [11:0] pc, input int k);
        logic [11:0] kk;
        kk = 12'(k);
        return {pc, 12'o1000 + kk, kk[0], 12'o0100 + kk, kk[1]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [11:0] pc, input int k);
        logic [11:0] kk;
        kk = 12'(k);
        bus.cpu_state = 4'b0000;
        bus.cpu_pc    = pc;
        bus.cpu_mb    = 12'o1000 + kk;
        bus.cpu_l     = kk[0];
        bus.cpu_ac    = 12'o0100 + kk;
        bus.cpu_ion   = kk[1];
        step();
        bus.cpu_state = 4'b0001;
        step();
    endtask

    task automatic arm_pulse(input logic wrap);
        bus.wrap_en = wrap;
        bus.arm     = 1'b1;
        step();
        bus.arm     = 1'b0;
    endtask

    task automatic rd(input string name, input logic [2:0] addr,
                      input logic [37:0] data, input logic err);
        rd_exp_t e;
        e.data = data;
        e.err  = err;
        e.name = name;
        sb.push_back(e);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        step();
        bus.rd_en   = 1'b0;
    endtask

    // Monitor: compare every presented read against the scoreboard head.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got data 0x%0h with no read pending", bus.rd_data);
            end else begin
                rd_exp_t e;
                e = sb.pop_front();
                check(e.name, {25'd0, bus.rd_err, bus.rd_data}, {25'd0, e.err, e.data});
            end
        end
    end

    initial begin
        reset          = 1'b1;
        bus.cpu_state  = 4'b0001;
        bus.cpu_pc     = '0;
        bus.cpu_mb     = '0;
        bus.cpu_l      = 1'b0;
        bus.cpu_ac     = '0;
        bus.cpu_ion    = 1'b0;
        bus.arm        = 1'b0;
        bus.stop       = 1'b0;
        bus.wrap_en    = 1'b0;
        bus.trig_pc_en = 1'b0;
        bus.trig_pc    = '0;
        bus.post_count = '0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state, stop ignored in IDLE, empty-buffer read
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_trig", 64'(bus.triggered), 64'd0);
        check("rst_entries", 64'(bus.entries), 64'd0);
        check("rst_cycles", 64'(bus.cycle_count), 64'd0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("idle_stop_done", 64'(bus.done), 64'd0);
        rd("rd_empty", 3'd0, 38'd0, 1'b1);

        // One-shot, 5 fetches
        arm_pulse(1'b0);
        for (int k = 0; k < 5; k++) fetch(12'o0200 + 12'(k), k);
        check("os5_entries", 64'(bus.entries), 64'd5);
        check("os5_busy", 64'(bus.busy), 64'd1);
        for (int k = 0; k < 5; k++) rd("os5_rd", 3'(k), exp_entry(12'o0200 + 12'(k), k), 1'b0);
        rd("os5_rd_err5", 3'd5, 38'd0, 1'b1);
        rd("os5_rd_err7", 3'd7, 38'd0, 1'b1);

        // Wrap mode, 11 fetches into 8 entries
        arm_pulse(1'b1);
        for (int k = 0; k < 11; k++) fetch(12'o0400 + 12'(k), k);
        check("wrap_entries", 64'(bus.entries), 64'd8);
        check("wrap_cycles", 64'(bus.cycle_count), 64'd11);
        check("wrap_busy", 64'(bus.busy), 64'd1);
        rd("wrap_rd0", 3'd0, exp_entry(12'o0403, 3), 1'b0);
        rd("wrap_rd7", 3'd7, exp_entry(12'o0412, 10), 1'b0);

        // One-shot fill, 10 fetches
        arm_pulse(1'b0);
        for (int k = 0; k < 10; k++) begin
            fetch(12'o0600 + 12'(k), k);
            if (k == 6) check("fill_done_k6", 64'(bus.done), 64'd0);
            if (k == 7) check("fill_done_k7", 64'(bus.done), 64'd1);
        end
        check("fill_entries", 64'(bus.entries), 64'd8);
        check("fill_cycles", 64'(bus.cycle_count), 64'd8);
        check("fill_busy", 64'(bus.busy), 64'd0);
        rd("fill_rd0", 3'd0, exp_entry(12'o0600, 0), 1'b0);
        rd("fill_rd7", 3'd7, exp_entry(12'o0607, 7), 1'b0);

        // PC trigger with post_count = 2
        bus.trig_pc_en = 1'b1;
        bus.trig_pc    = 12'o0300;
        bus.post_count = 4'd2;
        arm_pulse(1'b1);
        for (int k = 0; k < 6; k++) begin
            fetch(12'o0276 + 12'(k), k);
            if (k == 1) check("pc_trig_k1", 64'(bus.triggered), 64'd0);
            if (k == 3) check("pc_done_k3", 64'(bus.done), 64'd0);
            if (k == 4) check("pc_done_k4", 64'(bus.done), 64'd1);
        end
        check("pc_triggered", 64'(bus.triggered), 64'd1);
        check("pc_entries", 64'(bus.entries), 64'd5);
        rd("pc_last", 3'd4, exp_entry(12'o0302, 4), 1'b0);
        rd("pc_trig_entry", 3'd2, exp_entry(12'o0300, 2), 1'b0);
        bus.trig_pc_en = 1'b0;

        // Long fetch gives one entry, then halt trigger with post_count = 0
        bus.post_count = 4'd0;
        arm_pulse(1'b1);
        bus.cpu_state = 4'b0000;
        bus.cpu_pc    = 12'o0500;
        bus.cpu_mb    = 12'o1000;
        bus.cpu_l     = 1'b0;
        bus.cpu_ac    = 12'o0100;
        bus.cpu_ion   = 1'b0;
        step();
        step();
        step();
        bus.cpu_state = 4'b0001;
        step();
        check("long_fetch_entries", 64'(bus.entries), 64'd1);
        check("halt_pre_done", 64'(bus.done), 64'd0);
        bus.cpu_state = 4'b1100;
        step();
        bus.cpu_state = 4'b0001;
        check("halt_done", 64'(bus.done), 64'd1);
        check("halt_triggered", 64'(bus.triggered), 64'd1);
        rd("long_fetch_rd", 3'd0, exp_entry(12'o0500, 0), 1'b0);

        // arm mid-POST clears everything
        bus.trig_pc_en = 1'b1;
        bus.trig_pc    = 12'o0300;
        bus.post_count = 4'd3;
        arm_pulse(1'b1);
        fetch(12'o0300, 0);
        fetch(12'o0301, 1);
        check("post_entries", 64'(bus.entries), 64'd2);
        check("post_triggered", 64'(bus.triggered), 64'd1);
        arm_pulse(1'b1);
        bus.trig_pc_en = 1'b0;
        check("rearm_busy", 64'(bus.busy), 64'd1);
        check("rearm_entries", 64'(bus.entries), 64'd0);
        check("rearm_cycles", 64'(bus.cycle_count), 64'd0);
        check("rearm_triggered", 64'(bus.triggered), 64'd0);

        // stop, then arm + stop together
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("stop_done", 64'(bus.done), 64'd1);
        bus.stop = 1'b1;
        arm_pulse(1'b1);
        bus.stop = 1'b0;
        check("arm_stop_busy", 64'(bus.busy), 64'd1);
        check("arm_stop_done", 64'(bus.done), 64'd0);

        // reset mid-capture
        bus.post_count = 4'd0;
        fetch(12'o0700, 0);
        fetch(12'o0701, 1);
        bus.cpu_state = 4'b0000;
        bus.cpu_pc    = 12'o0702;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.cpu_state = 4'b0001;
        check("rstmid_busy", 64'(bus.busy), 64'd0);
        check("rstmid_done", 64'(bus.done), 64'd0);
        check("rstmid_trig", 64'(bus.triggered), 64'd0);
        check("rstmid_entries", 64'(bus.entries), 64'd0);
        check("rstmid_cycles", 64'(bus.cycle_count), 64'd0);
        check("rstmid_rd", {24'd0, bus.rd_valid, bus.rd_err, bus.rd_data}, 64'd0);

        step();
        step();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
